// File: rtl/l0_bank.sv
// l0_bank -- bank of ROW independent FIFOs sharing one write strobe, with
// either parallel or staggered (row i delayed by i cycles) read-out.
//
// Optional feature: define L0_BANK_ERR_EN to add the o_err port
// (bit0 sticky overflow, bit1 sticky underflow, cleared only by reset).
//
// Ports:
//   clk            sole clock, all state on rising edge
//   reset          asynchronous, active-low reset
//   in             write data, row i at [BW*(i+1)-1:BW*i]
//   wr             write request to all rows
//   rd             read request
//   mode           0 parallel read, 1 staggered read
//   out            registered read data, same slicing as in
//   out_valid      per-row pulse: out slice i updated this cycle
//   o_full         some row is full
//   o_almost_full  some row has occupancy >= AF_LEVEL
//   o_ready        every row is empty
//   o_err          (L0_BANK_ERR_EN only) sticky {underflow, overflow}
module l0_bank #(
  parameter int ROW      = 8,
  parameter int BW       = 4,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = DEPTH - 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROW*BW-1:0] in,
  input  logic              wr,
  input  logic              rd,
  input  logic              mode,
  output logic [ROW*BW-1:0] out,
  output logic [ROW-1:0]    out_valid,
  output logic              o_full,
  output logic              o_almost_full,
`ifdef L0_BANK_ERR_EN
  output logic              o_ready,
  output logic [1:0]        o_err
`else
  output logic              o_ready
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] AF_THR   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [ROW-1:0] rd_en;
  logic [ROW-1:0] full;
  logic [ROW-1:0] empty;
  logic [ROW-1:0] afull;
  logic [ROW-1:0] wr_row;
  logic [ROW-1:0] rd_row;

  // Read-enable stage: mode is applied every cycle to the current rd_en,
  // so switching mode mid-stream simply reshapes the pending enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en <= '0;
    end else if (mode) begin
      rd_en <= {rd_en[ROW-2:0], rd};
    end else begin
      rd_en <= {ROW{rd}};
    end
  end

  // Per-row FIFO and output register stage
  for (genvar i = 0; i < ROW; i++) begin : g_row
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   occ;
    logic [BW-1:0] mem [DEPTH];
    logic [BW-1:0] dout;
    logic          vld;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign occ       = wptr - rptr;
    assign empty[i]  = (wptr == rptr);
    assign full[i]   = (occ == FULL_OCC);
    assign afull[i]  = (occ >= AF_THR);
    // Both qualifiers use pre-edge state: a write to a full row is dropped
    // even with a concurrent read, and an empty row is not read even with
    // a concurrent write.
    assign wr_row[i] = wr & ~full[i];
    assign rd_row[i] = rd_en[i] & ~empty[i];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
        dout <= '0;
        vld  <= 1'b0;
      end else begin
        vld <= rd_row[i];
        if (wr_row[i]) begin
          wptr <= wptr + 1'b1;
        end
        if (rd_row[i]) begin
          rptr <= rptr + 1'b1;
          dout <= mem[rptr[AW-1:0]];
        end
      end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
      if (wr_row[i]) begin
        mem[wptr[AW-1:0]] <= in[BW*i +: BW];
      end
    end

    assign out[BW*i +: BW] = dout;
    assign out_valid[i]    = vld;
  end

  assign o_full        = |full;
  assign o_almost_full = |afull;
  assign o_ready       = &empty;

`ifdef L0_BANK_ERR_EN
  // Sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_err <= 2'b00;
    end else begin
      if (wr && (|full)) begin
        o_err[0] <= 1'b1;
      end
      if (|(rd_en & empty)) begin
        o_err[1] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l0_bank.sv
module tb_l0_bank;

  localparam int ROW      = 8;
  localparam int BW       = 4;
  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = 12;

  logic              clk;
  logic              reset;
  logic [ROW*BW-1:0] din;
  logic              wr;
  logic              rd;
  logic              mode;
  logic [ROW*BW-1:0] dout;
  logic [ROW-1:0]    out_valid;
  logic              o_full;
  logic              o_almost_full;
  logic              o_ready;
`ifdef L0_BANK_ERR_EN
  logic [1:0]        o_err;
`endif

  int n_vec;
  int n_err;

  l0_bank #(
    .ROW      (ROW),
    .BW       (BW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in            (din),
    .wr            (wr),
    .rd            (rd),
    .mode          (mode),
    .out           (dout),
    .out_valid     (out_valid),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
`ifdef L0_BANK_ERR_EN
    .o_ready       (o_ready),
    .o_err         (o_err)
`else
    .o_ready       (o_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] w [15];
  logic [31:0] last;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    din   = '0;
    wr    = 1'b0;
    rd    = 1'b0;
    mode  = 1'b0;
    tick();
    check("rst_out",   dout, 0);
    check("rst_vld",   out_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_full",  o_full, 0);
    check("rst_af",    o_almost_full, 0);
    reset = 1'b1;
    tick();

    // Parallel read of three entries
    wr = 1'b1;
    din = 32'h76543210; tick();
    din = 32'h87654321; tick();
    din = 32'h98765432; tick();
    wr = 1'b0;
    rd = 1'b1; tick();
    rd = 1'b0;
    check("par_lat_vld", out_valid, 8'h00);
    tick();
    check("par_out0", dout, 32'h76543210);
    check("par_vld0", out_valid, 8'hFF);
    tick();
    check("par_vld_drop", out_valid, 8'h00);
    check("par_hold", dout, 32'h76543210);
    rd = 1'b1; tick(); tick();
    rd = 1'b0;
    check("par_out1", dout, 32'h87654321);
    tick();
    check("par_out2", dout, 32'h98765432);
    tick();
    check("par_vld_end", out_valid, 8'h00);
    check("par_ready", o_ready, 1);

    // Staggered read of one entry
    wr = 1'b1; din = 32'h76543210; tick();
    wr = 1'b0;
    mode = 1'b1;
    rd = 1'b1; tick();
    rd = 1'b0;
    check("stg_lat_vld", out_valid, 8'h00);
    for (int i = 0; i < ROW; i++) begin
      tick();
      check($sformatf("stg_vld%0d", i), out_valid, 8'h01 << i);
      check($sformatf("stg_nib%0d", i), dout[BW*i +: BW], i);
    end
    tick();
    check("stg_vld_end", out_valid, 8'h00);
    check("stg_out", dout, 32'h76543210);
    check("stg_ready", o_ready, 1);
    mode = 1'b0;

    // Fill to full, overflow, drain
    wr = 1'b1;
    for (int k = 0; k < 16; k++) begin
      din = 32'h11111111 * k;
      tick();
      if (k == 10) check("af_below", o_almost_full, 0);
      if (k == 11) check("af_at12", o_almost_full, 1);
      if (k == 14) check("full_below", o_full, 0);
      if (k == 15) check("full_at16", o_full, 1);
    end
    din = 32'hFFFFFFFF; tick();
    wr = 1'b0;
    check("full_after_ovf", o_full, 1);
    rd = 1'b1; tick();
    for (int k = 0; k < 16; k++) begin
      if (k == 15) rd = 1'b0;
      tick();
      check($sformatf("drain%0d", k), dout, 32'h11111111 * k);
      check($sformatf("drain_vld%0d", k), out_valid, 8'hFF);
    end
    tick();
    check("drain_vld_end", out_valid, 8'h00);
    check("drain_ready", o_ready, 1);
    check("drain_af", o_almost_full, 0);
`ifdef L0_BANK_ERR_EN
    check("err_ovf", o_err, 2'b01);
`endif

    // Read of an empty bank
    last = dout;
    rd = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) rd = 1'b0;
      tick();
      check($sformatf("empty_out%0d", c), dout, last);
      check($sformatf("empty_vld%0d", c), out_valid, 8'h00);
    end
`ifdef L0_BANK_ERR_EN
    check("err_udf", o_err, 2'b11);
`endif

    // Concurrent read and write at occupancy 5
    for (int k = 0; k < 15; k++) w[k] = 32'h10203040 + 32'h01010101 * k;
    wr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din = w[k];
      tick();
    end
    for (int j = 0; j < 10; j++) begin
      din = w[5 + j];
      rd = 1'b1;
      tick();
      if (j >= 1) check($sformatf("rw_out%0d", j - 1), dout, w[j - 1]);
    end
    wr = 1'b0;
    rd = 1'b0;
    tick();
    check("rw_out9", dout, w[9]);
    rd = 1'b1; tick();
    for (int m = 0; m < 5; m++) begin
      if (m == 4) rd = 1'b0;
      tick();
      check($sformatf("rw_tail%0d", m), dout, w[10 + m]);
      if (m == 3) check("rw_not_empty", o_ready, 0);
    end
    tick();
    check("rw_ready", o_ready, 1);
    check("rw_vld_end", out_valid, 8'h00);

    // Reset in the middle of a staggered read
    wr = 1'b1;
    din = 32'h76543210; tick();
    din = 32'hFEDCBA98; tick();
    wr = 1'b0;
    mode = 1'b1;
    rd = 1'b1; tick();
    tick();
    rd = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out", dout, 0);
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_ready", o_ready, 1);
    tick();
    reset = 1'b1;
    for (int c = 0; c < ROW + 2; c++) begin
      tick();
      check($sformatf("post_rst_vld%0d", c), out_valid, 0);
    end
    check("post_rst_ready", o_ready, 1);
    check("post_rst_out", dout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/l0_bank.md
L0_BANK -- requirements
Module: l0_bank

Interface
REQ-001 SHALL have parameter ROW, default 8, number of row channels.
REQ-002 SHALL have parameter BW, default 4, bits per row entry.
REQ-003 SHALL have parameter DEPTH, default 64, entries per row, power of two, >= 4.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-4, almost-full occupancy threshold, 1..DEPTH.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in  input  ROW*BW  write data, row i at [BW*(i+1)-1:BW*i].
REQ-008 SHALL have port wr  input  1  write request to all rows.
REQ-009 SHALL have port rd  input  1  read request.
REQ-010 SHALL have port mode  input  1  read mode (0 parallel, 1 staggered).
REQ-011 SHALL have port out  output  ROW*BW  registered read data, same row slicing as in.
REQ-012 SHALL have port out_valid  output  ROW  per-row pulse, out slice i updated this cycle.
REQ-013 SHALL have port o_full  output  1  OR of per-row full.
REQ-014 SHALL have port o_almost_full  output  1  any row occupancy >= AF_LEVEL.
REQ-015 SHALL have port o_ready  output  1  AND of per-row empty.

Function
REQ-016 SHALL give each row an independent DEPTH-entry FIFO with pointers of log2(DEPTH)+1 bits; occupancy = wptr-rptr, wrap-around via MSB.
REQ-017 SHALL write slice i into row i when wr=1 and row i is not full (pre-edge); wr to a full row SHALL drop that row's slice only, other rows still write.
REQ-018 SHALL hold internal per-row read-enable register rd_en[ROW-1:0]: mode 0 -> rd_en <= {ROW{rd}}; mode 1 -> rd_en[0] <= rd, rd_en[i] <= rd_en[i-1].
REQ-019 SHALL apply mode every cycle; a mode change mid-stream updates rd_en from its current value per the new rule, no flush.
REQ-020 SHALL, when rd_en[i]=1 and row i not empty (pre-edge), register head entry into out slice i, advance rptr, assert out_valid[i] next cycle.
REQ-021 SHALL, when rd_en[i]=1 and row i empty, do nothing: pointer unchanged, out slice i held, out_valid[i]=0.
REQ-022 SHALL hold out slice i and drive out_valid[i]=0 on any cycle with no read of row i.
REQ-023 SHALL give latency rd at edge t -> row i data on out at edge t+2+i (mode 1), t+2 for all rows (mode 0).
REQ-024 SHALL allow simultaneous read and write of one row: both take effect, occupancy unchanged; read of an empty row with concurrent write reads nothing; write to a full row with concurrent read is dropped.
REQ-025 SHALL derive o_full, o_almost_full, o_ready combinationally from registered pointers.

Reset
REQ-026 SHALL, while reset=0, asynchronously clear all pointers, rd_en, out (to 0), out_valid (to 0), and error flags.
REQ-027 SHALL, after reset, give o_ready=1, o_full=0, o_almost_full=0; storage contents need not be cleared.
REQ-028 SHALL discard in-flight staggered enables and buffered data on reset mid-operation.

Configuration
REQ-029 SHALL, with macro L0_BANK_ERR_EN defined, add output o_err[1:0]: bit0 sticky overflow (wr to any full row), bit1 sticky underflow (rd_en[i]=1 on empty row i); cleared only by reset.
REQ-030 SHALL, without L0_BANK_ERR_EN, omit port o_err and all its logic; other behaviour identical.

Verification (ROW=8, BW=4, DEPTH=16, AF_LEVEL=12)
REQ-031 SHALL cover: reset low mid-stream -> out=0, out_valid=0, o_ready=1 immediately, before next clk.
REQ-032 SHALL cover: 3 writes in=32'h76543210,32'h87654321,32'h98765432; mode=0, rd 1 cycle -> 2 cycles later out=32'h76543210, out_valid=8'hFF for 1 cycle.
REQ-033 SHALL cover: 1 write 32'h76543210; mode=1, rd pulse 1 cycle -> out_valid = 8'h01,8'h02,...,8'h80 on consecutive cycles starting 2 cycles after rd; nibble i = i.
REQ-034 SHALL cover: 12 writes -> o_almost_full=1; 16 writes -> o_full=1; 17th write 32'hFFFFFFFF dropped, subsequent 16 reads return first 16 values; with L0_BANK_ERR_EN o_err=2'b01.
REQ-035 SHALL cover: empty bank, rd=1 for 3 cycles mode 0 -> out unchanged, out_valid=0; with L0_BANK_ERR_EN o_err[1]=1.
REQ-036 SHALL cover: occupancy 5, wr=1 and rd=1 together for 10 cycles mode 0 -> occupancy stays 5, data returned in write order.
